if_fetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the combinational instruction ROM.
- Owns the PC register and the ROM chip-enable (ce); captures the ROM's same-cycle inst together with its pc.
- Buffers captured pairs in a small FIFO that feeds the ID stage over a valid/ready handshake.
- Handles branch redirect, keeping exactly one delay slot, and exception flush.

---
 rtl/if_fetch_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns PC and ROM ce, buffers {pc, inst} pairs toward ID,
// and handles branch redirect with one delay slot and flush. FETCH_PERF_EN adds perf counters.
module if_fetch_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ce,
    output logic [31:0]                  pc,
    input  logic [31:0]                  inst_i,
    output logic                         id_valid_o,
    input  logic                         id_ready_i,
    output logic [31:0]                  id_pc_o,
    output logic [31:0]                  id_inst_o,
    input  logic                         branch_flag_i,
    input  logic [31:0]                  branch_target_addr_i,
    input  logic                         flush_i,
    input  logic [31:0]                  new_pc_i,
`ifdef FETCH_PERF_EN
    output logic [31:0]                  full_stall_cnt_o,
    output logic [31:0]                  redirect_cnt_o,
`endif
    output logic [$clog2(QUEUE_DEPTH):0] count_o
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic              ce_q;
    logic [31:0]       pc_q, pc_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]       inst_mem_q [QUEUE_DEPTH];

    logic              pop_s, fire_s, push_s;
    logic [CW-1:0]     remain_s;

    assign ce         = ce_q;
    assign pc         = pc_q;
    assign count_o    = count_q;
    assign id_valid_o = (count_q != {CW{1'b0}});
    assign id_pc_o    = id_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
    assign id_inst_o  = id_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0000_0000;

    assign pop_s    = id_valid_o && id_ready_i;
    assign fire_s   = ce_q && ((count_q < DEPTH_C) || pop_s);
    assign remain_s = count_q - CW'(pop_s);

    // Next PC, pointer and occupancy selection: flush > branch > sequential
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push_s   = 1'b0;
        if (flush_i) begin
            pc_d     = new_pc_i;
            rd_ptr_d = wr_ptr_q;
            count_d  = {CW{1'b0}};
        end else if (branch_flag_i) begin
            pc_d     = branch_target_addr_i;
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
            // The oldest surviving entry is the delay slot; otherwise fetch it now.
            if (remain_s != {CW{1'b0}}) begin
                wr_ptr_d = rd_ptr_d + PW'(1'b1);
                count_d  = CW'(1'b1);
            end else if (fire_s) begin
                push_s   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
                count_d  = CW'(1'b1);
            end else begin
                count_d  = {CW{1'b0}};
            end
        end else begin
            if (fire_s) begin
                push_s   = 1'b1;
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                pc_d     = pc_q;
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q     <= 1'b0;
            pc_q     <= RESET_PC;
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            ce_q     <= 1'b1;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are masked by id_valid_o so no reset is needed
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= inst_i;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] full_stall_cnt_q, full_stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    assign full_stall_cnt_o = full_stall_cnt_q;
    assign redirect_cnt_o   = redirect_cnt_q;

    // Saturating event counters
    always_comb begin
        full_stall_cnt_d = full_stall_cnt_q;
        redirect_cnt_d   = redirect_cnt_q;
        if (ce_q && (count_q == DEPTH_C) && !pop_s && (full_stall_cnt_q != 32'hFFFF_FFFF)) begin
            full_stall_cnt_d = full_stall_cnt_q + 32'd1;
        end else begin
            full_stall_cnt_d = full_stall_cnt_q;
        end
        if ((branch_flag_i || flush_i) && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            full_stall_cnt_q <= 32'h0000_0000;
            redirect_cnt_q   <= 32'h0000_0000;
        end else begin
            full_stall_cnt_q <= full_stall_cnt_d;
            redirect_cnt_q   <= redirect_cnt_d;
        end
    end
`endif

endmodule
